// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: synchronise and filter the raw lines, deframe
// 11-bit frames on filtered clock falls, decode E0/F0 prefixes into
// make/break events, and buffer the events in a FWFT FIFO.
module ps2_event_rx #(
  parameter int unsigned FILTER_LEN     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [9:0]                    ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]     sync1, sync2, filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_prev;
  logic           fall;
  logic           data_bit;

  // Two-stage synchroniser and persistence filter for both lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      filt     <= '1;
      clk_prev <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1    <= {ps2_data, ps2_clk};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall     = clk_prev & ~filt[0];
  assign data_bit = filt[1];

  state_t         state, state_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_bit, par_bit_n;
  logic [TCW-1:0] tcnt, tcnt_n;
  logic           byte_valid, byte_valid_n;
  logic           parity_err_n, frame_err_n;
  logic           timeout;

  assign timeout = (state != IDLE) && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

  // Frame FSM state and registered result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tcnt       <= tcnt_n;
      byte_valid <= byte_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  // Frame FSM next state: timeout outranks a fall in the same cycle
  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    tcnt_n       = tcnt;
    byte_valid_n = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    if (state == IDLE) begin
      tcnt_n = '0;
      if (fall && !data_bit) begin
        state_n   = DATA;
        bit_idx_n = '0;
      end
    end else if (timeout) begin
      frame_err_n = 1'b1;
      state_n     = IDLE;
      tcnt_n      = '0;
    end else if (fall) begin
      tcnt_n = '0;
      case (state)
        DATA: begin
          shreg_n   = {data_bit, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_bit;
          state_n   = STOP;
        end
        STOP: begin
          if (!data_bit)                   frame_err_n  = 1'b1;
          else if (!(^{shreg, par_bit}))   parity_err_n = 1'b1;
          else                             byte_valid_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      tcnt_n = tcnt + 1'b1;
    end
  end

  logic       ext, brk;
  logic       push_req;
  logic [9:0] push_data;

  // Prefix decoder: E0/F0 set flags, any other byte emits an event
  always_ff @(posedge clk) begin
    if (rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (parity_err || frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          push_req  <= 1'b1;
          push_data <= {brk, ext, shreg};
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
    end
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, do_push;

  assign fifo_level = wr_ptr - rd_ptr;
  assign ev_valid   = (fifo_level != '0);
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop        = ev_valid && ev_ready;
  assign do_push    = push_req && (!full || pop);
  assign ev_data    = mem[rd_ptr[AW-1:0]];

  // Event FIFO; when full, a push in the same cycle as a pop reuses the freed slot
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push_req && full && !pop;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_event_rx.sv
// Directed bench for ps2_event_rx with short filter, short timeout and a
// four-entry FIFO so every boundary is reachable quickly.
module tb_ps2_event_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] fifo_level;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;

  ps2_event_rx #(
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(50),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ev_data(ev_data),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .fifo_level(fifo_level),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters: each counts high cycles, so a single pulse adds exactly 1
  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
    if (overflow)   ovf_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Drive the first n bits of an 11-bit frame (LSB first), 40 clk per bit
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      tick(10);
      ps2_clk = 1'b0;
      tick(20);
      ps2_clk = 1'b1;
      tick(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bits({stop, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1);
  endtask

  task automatic pop_one;
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(5);
    checks++; if (ev_valid !== 1'b0)    begin errors++; $display("FAIL reset_ev_valid got %b exp 0", ev_valid); end
    checks++; if (fifo_level !== 3'd0)  begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (parity_err !== 1'b0)  begin errors++; $display("FAIL reset_parity_err got %b exp 0", parity_err); end
    checks++; if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_clean_make;
    int p0 = perr_cnt, f0 = ferr_cnt;
    send_frame(8'h1D, 1'b1, 1'b1);
    checks++; if (fifo_level !== 3'd1)   begin errors++; $display("FAIL make_level got %0d exp 1", fifo_level); end
    checks++; if (ev_valid !== 1'b1)     begin errors++; $display("FAIL make_valid got %b exp 1", ev_valid); end
    checks++; if (ev_data !== 10'h01D)   begin errors++; $display("FAIL make_data got %h exp 01d", ev_data); end
    checks++; if (perr_cnt - p0 + ferr_cnt - f0 != 0) begin errors++; $display("FAIL make_no_err got %0d exp 0", perr_cnt - p0 + ferr_cnt - f0); end
    pop_one();
    checks++; if (ev_valid !== 1'b0)     begin errors++; $display("FAIL make_pop_valid got %b exp 0", ev_valid); end
  endtask

  task automatic test_ext_break;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'h1D);
    checks++; if (fifo_level !== 3'd2)   begin errors++; $display("FAIL extbrk_level got %0d exp 2", fifo_level); end
    checks++; if (ev_data !== 10'h375)   begin errors++; $display("FAIL extbrk_data got %h exp 375", ev_data); end
    pop_one();
    checks++; if (ev_data !== 10'h01D)   begin errors++; $display("FAIL extbrk_after got %h exp 01d", ev_data); end
    pop_one();
    checks++; if (fifo_level !== 3'd0)   begin errors++; $display("FAIL extbrk_drain got %0d exp 0", fifo_level); end
  endtask

  task automatic test_parity_err;
    int p0 = perr_cnt, f0 = ferr_cnt;
    send_byte(8'hF0);
    send_frame(8'h1D, 1'b0, 1'b1);
    checks++; if (perr_cnt - p0 != 1)    begin errors++; $display("FAIL par_pulse got %0d exp 1", perr_cnt - p0); end
    checks++; if (ferr_cnt - f0 != 0)    begin errors++; $display("FAIL par_no_frame got %0d exp 0", ferr_cnt - f0); end
    checks++; if (fifo_level !== 3'd0)   begin errors++; $display("FAIL par_no_event got %0d exp 0", fifo_level); end
    send_byte(8'h1D);
    checks++; if (ev_data !== 10'h01D || ev_valid !== 1'b1) begin errors++; $display("FAIL par_flags_cleared got %h exp 01d", ev_data); end
    pop_one();
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++; if (ev_data !== 10'h21D || ev_valid !== 1'b1) begin errors++; $display("FAIL par_break_after got %h exp 21d", ev_data); end
    pop_one();
  endtask

  task automatic test_frame_err;
    int p0 = perr_cnt, f0 = ferr_cnt;
    send_frame(8'h1D, 1'b1, 1'b0);
    checks++; if (ferr_cnt - f0 != 1)    begin errors++; $display("FAIL stop_pulse got %0d exp 1", ferr_cnt - f0); end
    checks++; if (perr_cnt - p0 != 0)    begin errors++; $display("FAIL stop_no_parity got %0d exp 0", perr_cnt - p0); end
    checks++; if (fifo_level !== 3'd0)   begin errors++; $display("FAIL stop_no_event got %0d exp 0", fifo_level); end
  endtask

  task automatic test_timeout;
    int f0 = ferr_cnt;
    send_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 6);
    ps2_data = 1'b1;
    tick(15);
    checks++; if (ferr_cnt - f0 != 0)    begin errors++; $display("FAIL timeout_early got %0d exp 0", ferr_cnt - f0); end
    tick(60);
    checks++; if (ferr_cnt - f0 != 1)    begin errors++; $display("FAIL timeout_pulse got %0d exp 1", ferr_cnt - f0); end
    checks++; if (fifo_level !== 3'd0)   begin errors++; $display("FAIL timeout_no_event got %0d exp 0", fifo_level); end
    send_byte(8'h1C);
    checks++; if (ev_data !== 10'h01C || ev_valid !== 1'b1) begin errors++; $display("FAIL timeout_recover got %h exp 01c", ev_data); end
    pop_one();
  endtask

  task automatic test_overflow;
    int o0 = ovf_cnt;
    logic [9:0] exp_ev;
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k));
    checks++; if (ovf_cnt - o0 != 0)     begin errors++; $display("FAIL ovf_early got %0d exp 0", ovf_cnt - o0); end
    send_byte(8'h14);
    checks++; if (fifo_level !== 3'd4)   begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (ovf_cnt - o0 != 1)     begin errors++; $display("FAIL ovf_pulse got %0d exp 1", ovf_cnt - o0); end
    for (int k = 0; k < 4; k++) begin
      exp_ev = 10'h010 + 10'(k);
      checks++; if (ev_valid !== 1'b1 || ev_data !== exp_ev) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", k, ev_data, exp_ev); end
      pop_one();
    end
    checks++; if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_empty got %b/%0d exp 0/0", ev_valid, fifo_level); end
  endtask

  task automatic test_glitch;
    int p0 = perr_cnt, f0 = ferr_cnt;
    ps2_data = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(10);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
    end
    tick(10);
    ps2_data = 1'b1;
    tick(100);
    checks++; if (perr_cnt - p0 + ferr_cnt - f0 != 0) begin errors++; $display("FAIL glitch_no_err got %0d exp 0", perr_cnt - p0 + ferr_cnt - f0); end
    send_byte(8'h1D);
    checks++; if (ev_data !== 10'h01D || fifo_level !== 3'd1) begin errors++; $display("FAIL glitch_frame got %h/%0d exp 01d/1", ev_data, fifo_level); end
  endtask

  task automatic test_reset_mid;
    int p0 = perr_cnt, f0 = ferr_cnt;
    checks++; if (ev_valid !== 1'b1)     begin errors++; $display("FAIL rstmid_pre got %b exp 1", ev_valid); end
    send_bits({1'b1, odd_par(8'h2A), 8'h2A, 1'b0}, 4);
    ps2_data = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_clear got %b/%0d exp 0/0", ev_valid, fifo_level); end
    tick(100);
    checks++; if (perr_cnt - p0 + ferr_cnt - f0 != 0) begin errors++; $display("FAIL rstmid_no_err got %0d exp 0", perr_cnt - p0 + ferr_cnt - f0); end
    send_byte(8'h1C);
    checks++; if (ev_data !== 10'h01C || fifo_level !== 3'd1) begin errors++; $display("FAIL rstmid_frame got %h/%0d exp 01c/1", ev_data, fifo_level); end
    pop_one();
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b0;
    test_reset();
    test_clean_make();
    test_ext_break();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
